// File: rtl/lib_arbiter_pkg.sv
// Shared constants and event type for the AER receive path.
// AER_* give the default address/timestamp widths of the pixel array.
// aer_evt_t mirrors the packed word on the link, MSB first:
// {x, y, timestamp, polarity}.
package lib_arbiter_pkg;

  localparam int AER_ROW_ADD    = 6;
  localparam int AER_COL_ADD    = 6;
  localparam int AER_SIZE       = 16;
  localparam int AER_WIDTH      = AER_ROW_ADD + AER_COL_ADD + AER_SIZE + 1;
  localparam int EVT_FIFO_DEPTH = 8;
  localparam int AER_CNT_W      = 16;

  typedef struct packed {
    logic [AER_ROW_ADD-1:0] x;
    logic [AER_COL_ADD-1:0] y;
    logic [AER_SIZE-1:0]    ts;
    logic                   pol;
  } aer_evt_t;

endpackage

// File: rtl/aer_event_receiver_if.sv
// Bundle of the AER receiver data-path signals.
// master: event source + downstream consumer (drives evt_*, clr_i, out_ready_i).
// slave : the receiver (drives the decoded event, dt, flags, statistics).
// Handshake: the source side has no backpressure (evt_valid_i is a one-cycle
// strobe); downstream transfers when out_valid_o & out_ready_i are both high
// at a rising edge, and the receiver holds every out field stable while
// out_valid_o=1 and out_ready_i=0.
interface aer_event_receiver_if
  import lib_arbiter_pkg::*;
#(
  parameter int ROW_ADD    = AER_ROW_ADD,
  parameter int COL_ADD    = AER_COL_ADD,
  parameter int SIZE       = AER_SIZE,
  parameter int CNT_W      = AER_CNT_W,
  parameter int FIFO_DEPTH = EVT_FIFO_DEPTH
);

  localparam int WIDTH = ROW_ADD + COL_ADD + SIZE + 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic               evt_valid_i;
  logic [WIDTH-1:0]   evt_data_i;
  logic               clr_i;
  logic               out_ready_i;
  logic               out_valid_o;
  logic [ROW_ADD-1:0] x_add_o;
  logic [COL_ADD-1:0] y_add_o;
  logic [SIZE-1:0]    timestamp_o;
  logic               polarity_o;
  logic [SIZE-1:0]    dt_o;
  logic               first_o;
  logic               overflow_o;
  logic [CNT_W-1:0]   drop_cnt_o;
  logic [CNT_W-1:0]   on_cnt_o;
  logic [CNT_W-1:0]   off_cnt_o;
  logic [LVL_W-1:0]   fifo_level_o;

  modport master (
    output evt_valid_i, evt_data_i, clr_i, out_ready_i,
    input  out_valid_o, x_add_o, y_add_o, timestamp_o, polarity_o, dt_o,
           first_o, overflow_o, drop_cnt_o, on_cnt_o, off_cnt_o, fifo_level_o
  );

  modport slave (
    input  evt_valid_i, evt_data_i, clr_i, out_ready_i,
    output out_valid_o, x_add_o, y_add_o, timestamp_o, polarity_o, dt_o,
           first_o, overflow_o, drop_cnt_o, on_cnt_o, off_cnt_o, fifo_level_o
  );

endinterface

// File: rtl/aer_sync_fifo.sv
// Single-clock FIFO with show-ahead read data (rdata is the head entry
// whenever empty=0). A push while full is accepted only if a pop happens in
// the same cycle. Pointers carry one extra wrap bit so full/empty come from
// the MSB compare.
// Ports: clk, rst_n (async, active-low), push/wdata, pop/rdata,
//        full, empty, level (occupancy 0..DEPTH).
module aer_sync_fifo #(
  parameter int DW    = 29,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  assign rd_en = pop && !empty;
  // The slot freed by a same-cycle pop lets a push into a full FIFO.
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/aer_event_receiver.sv
// Receiving end of the AER event link.
// Pipeline: capture/dedup register -> event FIFO -> show-ahead output
// register with timestamp delta, plus saturating ON/OFF/drop statistics.
// Ports: clk_i, reset_i (async, active-low), bus (aer_event_receiver_if.slave)
//        carrying evt_valid_i/evt_data_i, clr_i, out_ready_i and all decoded
//        event, flag, statistic and FIFO-level outputs.
module aer_event_receiver
  import lib_arbiter_pkg::*;
#(
  parameter int ROW_ADD    = AER_ROW_ADD,
  parameter int COL_ADD    = AER_COL_ADD,
  parameter int SIZE       = AER_SIZE,
  parameter int WIDTH      = AER_WIDTH,
  parameter int FIFO_DEPTH = EVT_FIFO_DEPTH,
  parameter int CNT_W      = AER_CNT_W,
  parameter int DEDUP_EN   = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  aer_event_receiver_if.slave  bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- capture / dedup ----------------
  logic             cap_valid;
  logic [WIDTH-1:0] cap_data;
  logic [WIDTH-1:0] hist_data;
  logic             hist_valid;
  logic             hist_recent;  // a word was seen at the previous edge
  logic             dup;

  assign dup = (DEDUP_EN != 0) && hist_valid && hist_recent &&
               (bus.evt_data_i == hist_data);

  // A discarded duplicate still refreshes hist_recent, so a word held for
  // several cycles yields one event; one idle cycle re-arms it.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cap_valid   <= 1'b0;
      cap_data    <= '0;
      hist_data   <= '0;
      hist_valid  <= 1'b0;
      hist_recent <= 1'b0;
    end else begin
      cap_valid   <= bus.evt_valid_i && !dup;
      hist_recent <= bus.evt_valid_i;
      if (bus.evt_valid_i) begin
        cap_data  <= bus.evt_data_i;
        hist_data <= bus.evt_data_i;
      end
      if (bus.clr_i)            hist_valid <= 1'b0;
      else if (bus.evt_valid_i) hist_valid <= 1'b1;
    end
  end

  // ---------------- event FIFO ----------------
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_head;
  logic [LVL_W-1:0] fifo_level;

  logic             out_valid;
  logic             load_out;
  logic             xfer;
  logic             drop;

  assign xfer     = out_valid && bus.out_ready_i;
  assign load_out = !out_valid || bus.out_ready_i;
  assign fifo_pop = load_out && !fifo_empty;
  assign drop     = cap_valid && fifo_full && !fifo_pop;

  aer_sync_fifo #(
    .DW    (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (reset_i),
    .push  (cap_valid),
    .wdata (cap_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // ---------------- output register + dt ----------------
  logic [ROW_ADD-1:0] head_x;
  logic [COL_ADD-1:0] head_y;
  logic [SIZE-1:0]    head_ts;
  logic               head_pol;

  assign head_x   = fifo_head[WIDTH-1 -: ROW_ADD];
  assign head_y   = fifo_head[WIDTH-1-ROW_ADD -: COL_ADD];
  assign head_ts  = fifo_head[SIZE:1];
  assign head_pol = fifo_head[0];

  logic [ROW_ADD-1:0] x_q;
  logic [COL_ADD-1:0] y_q;
  logic [SIZE-1:0]    ts_q;
  logic               pol_q;
  logic [SIZE-1:0]    dt_q;
  logic               first_out_q;
  logic               first_q;
  logic [SIZE-1:0]    prev_ts;
  logic               first_eff;
  logic [SIZE-1:0]    prev_eff;

  // An event loaded in the same cycle as a transfer measures dt against the
  // event leaving now; clr_i in that cycle makes the new load a first event.
  always_comb begin
    first_eff = first_q;
    prev_eff  = prev_ts;
    if (xfer) begin
      first_eff = 1'b0;
      prev_eff  = ts_q;
    end
    if (bus.clr_i) first_eff = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_valid   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      ts_q        <= '0;
      pol_q       <= 1'b0;
      dt_q        <= '0;
      first_out_q <= 1'b1;
    end else if (load_out) begin
      out_valid <= !fifo_empty;
      if (!fifo_empty) begin
        x_q         <= head_x;
        y_q         <= head_y;
        ts_q        <= head_ts;
        pol_q       <= head_pol;
        dt_q        <= first_eff ? '0 : (head_ts - prev_eff);
        first_out_q <= first_eff;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      first_q <= 1'b1;
      prev_ts <= '0;
    end else if (bus.clr_i) begin
      first_q <= 1'b1;
      prev_ts <= '0;
    end else if (xfer) begin
      first_q <= 1'b0;
      prev_ts <= ts_q;
    end
  end

  // ---------------- statistics ----------------
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] off_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;

  // clr_i takes priority over any increment in the same cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      on_cnt   <= '0;
      off_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (bus.clr_i) begin
      on_cnt   <= '0;
      off_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (xfer && pol_q && on_cnt != CNT_MAX)    on_cnt   <= on_cnt + 1'b1;
      if (xfer && !pol_q && off_cnt != CNT_MAX)  off_cnt  <= off_cnt + 1'b1;
      if (drop && drop_cnt != CNT_MAX)           drop_cnt <= drop_cnt + 1'b1;
      if (drop)                                  overflow <= 1'b1;
    end
  end

  assign bus.out_valid_o  = out_valid;
  assign bus.x_add_o      = x_q;
  assign bus.y_add_o      = y_q;
  assign bus.timestamp_o  = ts_q;
  assign bus.polarity_o   = pol_q;
  assign bus.dt_o         = dt_q;
  assign bus.first_o      = first_out_q;
  assign bus.overflow_o   = overflow;
  assign bus.drop_cnt_o   = drop_cnt;
  assign bus.on_cnt_o     = on_cnt;
  assign bus.off_cnt_o    = off_cnt;
  assign bus.fifo_level_o = fifo_level;

endmodule

// File: tb/tb_aer_event_receiver.sv
// Bench for aer_event_receiver with default widths (6/6/16, depth 8).
module tb_aer_event_receiver;
  import lib_arbiter_pkg::*;

  logic clk;
  logic rst_n;

  aer_event_receiver_if bus ();

  aer_event_receiver dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [15:0] ts;
    logic        pol;
    logic [15:0] dt;
    logic        first;
    logic [15:0] on;
    logic [15:0] off;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [AER_WIDTH-1:0] pk(input logic [5:0] x, input logic [5:0] y,
                                               input logic [15:0] ts, input logic pol);
    aer_evt_t e;
    e.x   = x;
    e.y   = y;
    e.ts  = ts;
    e.pol = pol;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [AER_WIDTH-1:0] w);
    bus.evt_valid_i = 1'b1;
    bus.evt_data_i  = w;
    step();
    bus.evt_valid_i = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_i = 1'b1;
    step();
    bus.clr_i = 1'b0;
  endtask

  // One isolated event with ready=1: checks latency, fields and counters.
  task automatic apply_vec(input vec_t v, input int idx);
    bus.evt_valid_i = 1'b1;
    bus.evt_data_i  = pk(v.x, v.y, v.ts, v.pol);
    step();                                   // edge N: capture
    bus.evt_valid_i = 1'b0;
    step();                                   // edge N+1: FIFO write
    check($sformatf("v%0d_lat_early", idx), bus.out_valid_o, 0);
    step();                                   // edge N+2: output load
    check($sformatf("v%0d_valid", idx), bus.out_valid_o, 1);
    check($sformatf("v%0d_x", idx),     bus.x_add_o, v.x);
    check($sformatf("v%0d_y", idx),     bus.y_add_o, v.y);
    check($sformatf("v%0d_ts", idx),    bus.timestamp_o, v.ts);
    check($sformatf("v%0d_pol", idx),   bus.polarity_o, v.pol);
    check($sformatf("v%0d_dt", idx),    bus.dt_o, v.dt);
    check($sformatf("v%0d_first", idx), bus.first_o, v.first);
    step();                                   // edge N+3: transfer
    check($sformatf("v%0d_gone", idx),  bus.out_valid_o, 0);
    check($sformatf("v%0d_on", idx),    bus.on_cnt_o, v.on);
    check($sformatf("v%0d_off", idx),   bus.off_cnt_o, v.off);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},    bus.out_valid_o, 0);
    check({tag, "_level"},    bus.fifo_level_o, 0);
    check({tag, "_first"},    bus.first_o, 1);
    check({tag, "_on"},       bus.on_cnt_o, 0);
    check({tag, "_off"},      bus.off_cnt_o, 0);
    check({tag, "_drop"},     bus.drop_cnt_o, 0);
    check({tag, "_overflow"}, bus.overflow_o, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt;
    int c;
    logic [31:0] e;

    //      x   y   ts        pol  dt        first on  off
    vecs[0] = '{6'd5,  6'd9,  16'h0010, 1'b1, 16'h0000, 1'b1, 16'd1, 16'd0};
    vecs[1] = '{6'd1,  6'd2,  16'h0030, 1'b0, 16'h0020, 1'b0, 16'd1, 16'd1};
    vecs[2] = '{6'd63, 6'd63, 16'hFFF0, 1'b1, 16'hFFC0, 1'b0, 16'd2, 16'd1};
    vecs[3] = '{6'd0,  6'd0,  16'h0008, 1'b0, 16'h0018, 1'b0, 16'd2, 16'd2};
    vecs[4] = '{6'd10, 6'd20, 16'h0008, 1'b1, 16'h0000, 1'b0, 16'd3, 16'd2};
    vecs[5] = '{6'd7,  6'd3,  16'h1234, 1'b0, 16'h0000, 1'b1, 16'd0, 16'd1};

    bus.evt_valid_i = 1'b0;
    bus.evt_data_i  = '0;
    bus.clr_i       = 1'b0;
    bus.out_ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    check_reset_state("rst");
    rst_n = 1'b1;
    step();

    // Single events, wrap-around dt, first flag, ON/OFF counts.
    for (int i = 0; i < 5; i++) apply_vec(vecs[i], i);

    // Dedup: same word held 3 cycles -> 1 event; after an idle gap -> another.
    cnt = 0;
    bus.evt_data_i  = pk(6'd33, 6'd44, 16'h0200, 1'b1);
    bus.evt_valid_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.out_valid_o) cnt++;
      bus.evt_valid_i = (i == 0 || i == 1 || i == 3);
    end
    check("dedup_count", cnt, 2);
    check("dedup_on", bus.on_cnt_o, 5);

    // Overflow: ready=0, 12 distinct back-to-back events.
    pulse_clr();
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 12; k++)
      send(pk(6'(k), 6'(k + 1), 16'(16'h0100 + k), k[0]));
    repeat (3) step();
    check("ovf_level", bus.fifo_level_o, 8);
    check("ovf_valid", bus.out_valid_o, 1);
    check("ovf_head_ts", bus.timestamp_o, 16'h0100);
    check("ovf_first", bus.first_o, 1);
    check("ovf_drop", bus.drop_cnt_o, 3);
    check("ovf_flag", bus.overflow_o, 1);
    for (int k = 0; k < 9; k++) exp_q.push_back(32'h0100 + k);
    bus.out_ready_i = 1'b1;
    for (c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (bus.out_valid_o) begin
        e = exp_q.pop_front();
        check("drain_ts", bus.timestamp_o, e);
      end
      step();
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_cycles", c, 9);
    check("drain_on", bus.on_cnt_o, 4);
    check("drain_off", bus.off_cnt_o, 5);
    check("drain_empty", bus.out_valid_o, 0);

    // Full FIFO with simultaneous pop and push; clr_i with an ON delivery.
    pulse_clr();
    check("clr_drop", bus.drop_cnt_o, 0);
    check("clr_ovf", bus.overflow_o, 0);
    check("clr_on", bus.on_cnt_o, 0);
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 9; k++)
      send(pk(6'(k + 20), 6'(k), 16'(16'h0300 + k), 1'b1));
    repeat (3) step();
    check("full_level", bus.fifo_level_o, 8);
    bus.evt_valid_i = 1'b1;
    bus.evt_data_i  = pk(6'd40, 6'd41, 16'h03FF, 1'b1);
    step();                                   // capture
    bus.evt_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    step();                                   // pop + push together
    bus.out_ready_i = 1'b0;
    check("pp_level", bus.fifo_level_o, 8);
    check("pp_drop", bus.drop_cnt_o, 0);
    check("pp_on", bus.on_cnt_o, 1);
    check("pp_ts", bus.timestamp_o, 16'h0301);
    check("pp_dt", bus.dt_o, 16'h0001);
    bus.clr_i       = 1'b1;
    bus.out_ready_i = 1'b1;
    step();                                   // ON delivery + clr
    bus.clr_i       = 1'b0;
    bus.out_ready_i = 1'b0;
    check("clrx_on", bus.on_cnt_o, 0);
    check("clrx_ts", bus.timestamp_o, 16'h0302);
    check("clrx_first", bus.first_o, 1);
    check("clrx_dt", bus.dt_o, 0);

    // Reset with 4 events buffered.
    bus.out_ready_i = 1'b1;
    repeat (12) step();
    bus.out_ready_i = 1'b0;
    check("pre_rst_drained", bus.fifo_level_o, 0);
    for (int k = 0; k < 5; k++)
      send(pk(6'(k), 6'(k + 8), 16'(16'h0500 + k), 1'b0));
    repeat (3) step();
    check("pre_rst_level", bus.fifo_level_o, 4);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", bus.out_valid_o, 0);
    step();
    rst_n = 1'b1;
    check_reset_state("rst2");
    bus.out_ready_i = 1'b1;
    step();
    apply_vec(vecs[5], 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
